craft_round_controller: RTL and testbench

//   Sequencer for the nibble-serial CRAFT datapath. Runs ROUNDS rounds of NIBBLES cycles each.

---
 rtl/craft_round_controller.sv | 128 ++++++++++++
 tb/tb_craft_round_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/craft_round_controller.sv
// craft_round_controller: round/nibble sequencer for the nibble-serial CRAFT datapath.
// Optional build define CRAFT_STALL_EN adds a stall input that freezes a running operation.
module craft_round_controller #(
  parameter int ROUNDS  = 32,
  parameter int NIBBLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done_ready,
`ifdef CRAFT_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       en,
  output logic       ck0,
  output logic [7:0] r,
  output logic [3:0] nib,
  output logic       last_round,
  output logic       done_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] R_LAST = 8'(ROUNDS - 1);
  localparam logic [3:0] N_LAST = 4'(NIBBLES - 1);

  state_t     state_r, state_s;
  logic [7:0] round_r, round_s;
  logic [3:0] nib_r, nib_s;
  logic       busy_r, en_r, ck0_r, last_r, done_valid_r;
  logic [7:0] r_out_r;
  logic [3:0] nib_out_r;
  logic       stall_s;

`ifdef CRAFT_STALL_EN
  assign stall_s = stall;
`else
  assign stall_s = 1'b0;
`endif

  // Next-state and counter update logic.
  always_comb begin
    state_s = state_r;
    round_s = round_r;
    nib_s   = nib_r;
    case (state_r)
      IDLE: begin
        round_s = 8'd0;
        nib_s   = 4'd0;
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stall_s) begin
          state_s = RUN;
        end else if (nib_r < N_LAST) begin
          nib_s = nib_r + 4'd1;
        end else begin
          nib_s = 4'd0;
          if (round_r < R_LAST) begin
            round_s = round_r + 8'd1;
          end else begin
            state_s = DONE;
          end
        end
      end
      DONE: begin
        nib_s = 4'd0;
        if (done_ready) begin
          state_s = IDLE;
          round_s = 8'd0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        round_s = 8'd0;
        nib_s   = 4'd0;
      end
    endcase
  end

  // State, counters, and outputs pre-decoded from the next state so they register cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      round_r      <= 8'd0;
      nib_r        <= 4'd0;
      busy_r       <= 1'b0;
      en_r         <= 1'b0;
      ck0_r        <= 1'b0;
      last_r       <= 1'b0;
      done_valid_r <= 1'b0;
      r_out_r      <= 8'd0;
      nib_out_r    <= 4'd0;
    end else begin
      state_r      <= state_s;
      round_r      <= round_s;
      nib_r        <= nib_s;
      busy_r       <= (state_s != IDLE);
      en_r         <= (state_s == RUN);
      ck0_r        <= (state_s == RUN) && (nib_s == 4'd0);
      last_r       <= (state_s == RUN) && (round_s == R_LAST);
      done_valid_r <= (state_s == DONE);
      r_out_r      <= round_s;
      nib_out_r    <= nib_s;
    end
  end

  // A stalled RUN cycle must not clock the datapath, so stall gates en/ck0 directly.
  assign en         = en_r & ~stall_s;
  assign ck0        = ck0_r & ~stall_s;
  assign busy       = busy_r;
  assign r          = r_out_r;
  assign nib        = nib_out_r;
  assign last_round = last_r;
  assign done_valid = done_valid_r;

endmodule

// File: tb/tb_craft_round_controller.sv
// Scoreboard bench for craft_round_controller: expected ck0/done events are queued by stimulus
// and popped by a negedge monitor; stall scenario is built only with CRAFT_STALL_EN.
module tb_craft_round_controller;
  localparam int ROUNDS  = 32;
  localparam int NIBBLES = 16;

  logic       clk = 1'b0;
  logic       rst, start, done_ready;
`ifdef CRAFT_STALL_EN
  logic       stall;
`endif
  logic       busy, en, ck0, last_round, done_valid;
  logic [7:0] r;
  logic [3:0] nib;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit is_done;
    int rnd;
  } exp_t;
  exp_t exp_q[$];

  int en_cnt = 0, last_cnt = 0, dv_cnt = 0, run_cnt = 0;
  int s_en, s_last, s_dv, s_run;

  craft_round_controller #(.ROUNDS(ROUNDS), .NIBBLES(NIBBLES)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .done_ready(done_ready),
`ifdef CRAFT_STALL_EN
    .stall(stall),
`endif
    .busy(busy),
    .en(en),
    .ck0(ck0),
    .r(r),
    .nib(nib),
    .last_round(last_round),
    .done_valid(done_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: count activity and score every ck0 pulse and done acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (en) en_cnt++;
      if (last_round) last_cnt++;
      if (done_valid) dv_cnt++;
      if (busy && !done_valid) run_cnt++;
      if (ck0) begin
        if (exp_q.size() == 0) begin
          check("unexpected ck0", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ck0 kind", 32'(e.is_done), 32'd0);
          check("ck0 r", 32'(r), 32'(e.rnd));
          check("ck0 nib", 32'(nib), 32'd0);
          check("ck0 en", 32'(en), 32'd1);
        end
      end
      if (done_valid && done_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done kind", 32'(e.is_done), 32'd1);
          check("done r", 32'(r), 32'(e.rnd));
          check("done en/ck0/nib", 32'({en, ck0, nib}), 32'd0);
        end
      end
    end
  end

  task automatic push_run();
    exp_t e;
    for (int i = 0; i < ROUNDS; i++) begin
      e.is_done = 1'b0;
      e.rnd     = i;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.rnd     = ROUNDS - 1;
    exp_q.push_back(e);
  endtask

  task automatic start_op();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic snap();
    s_en   = en_cnt;
    s_last = last_cnt;
    s_dv   = dv_cnt;
    s_run  = run_cnt;
  endtask

  task automatic wait_rn(input int rr, input int nn, input string name);
    bit hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      hit = (r == 8'(rr)) && (nib == 4'(nn)) && en;
    end
    if (!hit) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_dv(input string name);
    bit hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      hit = done_valid;
    end
    if (!hit) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      hit = !busy;
    end
    if (!hit) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    done_ready = 1'b0;
`ifdef CRAFT_STALL_EN
    stall      = 1'b0;
`endif
    // 1: reset with start held high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset outs", 32'({busy, en, ck0, done_valid, last_round, r, nib}), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post-reset outs", 32'({busy, en, ck0, done_valid, last_round, r, nib}), 32'd0);

    // 2: full run at defaults
    done_ready = 1'b1;
    push_run();
    snap();
    start_op();
    wait_idle("full run");
    check("full en cycles", 32'(en_cnt - s_en), 32'd512);
    check("full run cycles", 32'(run_cnt - s_run), 32'd512);
    check("full last_round cycles", 32'(last_cnt - s_last), 32'd16);
    check("full done_valid cycles", 32'(dv_cnt - s_dv), 32'd1);
    check("full idle r", 32'(r), 32'd0);
    check("full queue empty", 32'(exp_q.size()), 32'd0);

    // 3: backpressure on completion
    done_ready = 1'b0;
    push_run();
    start_op();
    wait_dv("bp done");
    for (int i = 0; i < 10; i++) begin
      check("bp hold", 32'({done_valid, en, ck0, r}), 32'({1'b1, 1'b0, 1'b0, 8'd31}));
      if (i < 9) @(negedge clk);
    end
    @(posedge clk);
    #1 done_ready = 1'b1;
    @(negedge clk);
    check("bp accept cycle dv", 32'(done_valid), 32'd1);
    @(negedge clk);
    check("bp idle", 32'({busy, done_valid, r}), 32'd0);

    // 4: start ignored mid-run and in the done-accept cycle
    push_run();
    snap();
    start_op();
    wait_rn(3, 7, "ign r3n7");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_dv("ign done");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ign stays idle", 32'({busy, en, r}), 32'd0);
    end
    check("ign en cycles", 32'(en_cnt - s_en), 32'd512);
    check("ign queue empty", 32'(exp_q.size()), 32'd0);

    // 5: mid-run asynchronous reset
    for (int i = 0; i <= 5; i++) begin
      exp_t e;
      e.is_done = 1'b0;
      e.rnd     = i;
      exp_q.push_back(e);
    end
    start_op();
    wait_rn(5, 9, "mid r5n9");
    #1 rst = 1'b1;
    #1 check("async reset outs", 32'({busy, en, ck0, done_valid, last_round, r, nib}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid ck0 count", 32'(exp_q.size()), 32'd0);
    push_run();
    snap();
    start_op();
    wait_idle("after reset run");
    check("after reset en cycles", 32'(en_cnt - s_en), 32'd512);

`ifdef CRAFT_STALL_EN
    // 6: stall four cycles at r=2, nib=15
    push_run();
    snap();
    start_op();
    wait_rn(2, 14, "stall r2n14");
    @(posedge clk);
    #1 stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall hold", 32'({en, ck0, r, nib}), 32'({1'b0, 1'b0, 8'd2, 4'd15}));
      if (i == 3) begin
        @(posedge clk);
        #1 stall = 1'b0;
      end
    end
    @(negedge clk);
    check("stall release", 32'({en, ck0, r, nib}), 32'({1'b1, 1'b0, 8'd2, 4'd15}));
    @(negedge clk);
    check("stall next round", 32'({en, ck0, r, nib}), 32'({1'b1, 1'b1, 8'd3, 4'd0}));
    wait_idle("stall run");
    check("stall run cycles", 32'(run_cnt - s_run), 32'd516);
    check("stall en cycles", 32'(en_cnt - s_en), 32'd512);
`endif

    check("final queue empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
